// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared geometry, FSM state type and address field helpers for the
// direct-mapped write-back data cache (dcache_sram_ctrl / dcache_sram).
// The cache geometry is fixed here; the top-level parameters default to these
// values and must be left consistent with them.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int CACHE_LINES  = 32;
  localparam int CACHE_LINE_W = 256;
  localparam int CACHE_ADDR_W = 32;
  localparam int WORD_W       = 32;

  localparam int OFF_W  = 5;                               // byte offset in a line
  localparam int IDX_W  = $clog2(CACHE_LINES);             // line index
  localparam int TAG_W  = CACHE_ADDR_W - IDX_W - OFF_W;    // 22 at defaults
  localparam int WSEL_W = OFF_W - 2;                       // word select in a line

  typedef logic [CACHE_ADDR_W-1:0] addr_t;
  typedef logic [CACHE_LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]        tag_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [WSEL_W-1:0]       wsel_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[CACHE_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic wsel_t addr_word(input addr_t a);
    return a[OFF_W-1:2];
  endfunction

  // Line-aligned memory address; the byte offset is always zero.
  function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input line_t line, input wsel_t sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// -----------------------------------------------------------------------------
// dcache_sram
// Tag/valid/dirty array plus line data array for the direct-mapped cache.
// Reads are asynchronous on idx; writes are synchronous, either a full-line
// refill (sets valid, clears dirty, loads tag) or a single-word store (sets
// dirty). A refill takes priority over a word store.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (valid/dirty only)
//   idx                   line index for both read and write
//   word_sel              word within the line for word stores
//   word_we, word_data    single-word store
//   line_we, line_tag,
//   line_data             full-line refill
//   rd_valid, rd_dirty,
//   rd_tag, rd_line       contents of line idx
// -----------------------------------------------------------------------------
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = CACHE_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  idx_t        idx,
  input  wsel_t       word_sel,
  input  logic        word_we,
  input  logic [31:0] word_data,
  input  logic        line_we,
  input  tag_t        line_tag,
  input  line_t       line_data,
  output logic        rd_valid,
  output logic        rd_dirty,
  output tag_t        rd_tag,
  output line_t       rd_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  tag_t                 tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; clearing valid is
  // enough to make their contents unobservable, and it keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_data;
      tag_q[idx]  <= line_tag;
    end else if (word_we) begin
      data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_sram_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_sram_ctrl
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a line-wide memory. Hits complete combinationally (loads) or at the next
// edge (stores); misses stall the pipeline while the victim is written back
// (if dirty) and the line is refilled, after which the access replays as a hit.
//
// Ports:
//   clk_i, rst_i                clock, asynchronous active-low reset
//   p1_MemRead_i/p1_MemWrite_i  CPU load/store request (both high = store)
//   p1_addr_i, p1_data_i        CPU byte address and store data
//   p1_data_o, p1_stall_o       load data and pipeline stall
//   mem_addr_o, mem_data_o      line address and write-back data
//   mem_enable_o, mem_write_o   memory request level and direction
//   mem_data_i, mem_ack_i       refill data and one-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_sram_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = CACHE_LINES,
  parameter int LINE_W    = CACHE_LINE_W,
  parameter int ADDR_W    = CACHE_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_t state_q, state_d;

  tag_t  req_tag;
  idx_t  req_idx;
  wsel_t req_word;
  logic  req;
  logic  hit;
  logic  stall_raw;
  logic  word_we;
  logic  line_we;

  logic  rd_valid, rd_dirty;
  tag_t  rd_tag;
  line_t rd_line;

  logic  unused_byte_off;

  assign req_tag  = addr_tag(p1_addr_i);
  assign req_idx  = addr_idx(p1_addr_i);
  assign req_word = addr_word(p1_addr_i);
  assign unused_byte_off = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = rd_valid & (rd_tag == req_tag);

  // Stores land only once the line is present and the FSM is back in IDLE.
  assign word_we = (state_q == IDLE) & p1_MemWrite_i & hit;
  assign line_we = (state_q == REFILL) & mem_ack_i;

  dcache_sram #(
    .NUM_LINES (NUM_LINES)
  ) u_sram (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .idx       (req_idx),
    .word_sel  (req_word),
    .word_we   (word_we),
    .word_data (p1_data_i),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_data_i),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
      end
      WRITEBACK:   if (mem_ack_i) state_d = REFILL;
      REFILL:      if (mem_ack_i) state_d = REFILL_DONE;
      REFILL_DONE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output logic
  // NOTE: every output gets a default before the case so no path through the
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    stall_raw    = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall_raw = ~hit;
          if (hit && !p1_MemWrite_i) p1_data_o = line_word(rd_line, req_word);
        end
      end
      WRITEBACK: begin
        stall_raw    = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(rd_tag, req_idx);
        mem_data_o   = rd_line;
      end
      REFILL: begin
        stall_raw    = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(req_tag, req_idx);
      end
      REFILL_DONE: stall_raw = 1'b1;
      default:     stall_raw = 1'b0;
    endcase
  end

  // While reset is held the cleared valid bits would make a pending request
  // look like a miss; the stall is masked so every output reads zero.
  assign p1_stall_o = rst_i & stall_raw;

endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_sram_ctrl
// Directed bench for dcache_sram_ctrl with a line-wide memory model. The
// memory acks on the MEM_LAT-th cycle of a request and needs one turnaround
// cycle after every ack before it starts counting the next request. Unwritten
// lines read back as word w of line a = 0xA000_0000 + a + w.
// -----------------------------------------------------------------------------
module tb_dcache_sram_ctrl;

  localparam int MEM_LAT = 3;
  localparam int BUDGET  = 40;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  logic [255:0] mem_rdata = '0;
  logic         mem_ack_m = 1'b0;
  logic         force_ack = 1'b0;
  int           mem_cnt = 0;
  logic [255:0] mem_lines [logic [31:0]];

  int errors = 0;
  int checks = 0;

  // Captured during a miss
  logic         seen_wb, seen_rf, wb_first;
  logic [31:0]  wb_addr, rf_addr;
  logic [255:0] wb_line;
  int           n_stall;

  assign mem_data_i = mem_rdata;
  assign mem_ack_i  = mem_ack_m | force_ack;

  always #5 clk_i = ~clk_i;

  dcache_sram_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA000_0000 + a + w;
    return l;
  endfunction

  // Memory model, evaluated mid-cycle so the ack is stable at the next edge.
  always @(negedge clk_i) begin
    if (mem_ack_m) begin
      mem_ack_m = 1'b0;
      mem_cnt   = 0;
    end else if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt == MEM_LAT) begin
        mem_ack_m = 1'b1;
        if (mem_write_o) mem_lines[mem_addr_o] = mem_data_o;
        else mem_rdata = mem_lines.exists(mem_addr_o) ? mem_lines[mem_addr_o]
                                                      : pattern_line(mem_addr_o);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = a;
    p1_data_i     = d;
    #1;
  endtask

  // Counts stalled cycles of the current miss and records memory traffic.
  task automatic run_miss();
    n_stall  = 0;
    seen_wb  = 1'b0;
    seen_rf  = 1'b0;
    wb_first = 1'b0;
    wb_addr  = '0;
    rf_addr  = '0;
    wb_line  = '0;
    while (p1_stall_o && n_stall < BUDGET) begin
      if (mem_enable_o && mem_write_o && !seen_wb) begin
        seen_wb  = 1'b1;
        wb_addr  = mem_addr_o;
        wb_line  = mem_data_o;
        wb_first = !seen_rf;
      end
      if (mem_enable_o && !mem_write_o && !seen_rf) begin
        seen_rf = 1'b1;
        rf_addr = mem_addr_o;
      end
      n_stall++;
      step();
    end
    check("miss_within_budget", 32'(n_stall < BUDGET), 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    check("rst_stall", 32'(p1_stall_o), 32'd0);
    check("rst_data", p1_data_o, 32'h0);
    check("rst_enable", 32'(mem_enable_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    step();
    rst_i = 1'b1;
    #1;
    check("idle_no_req_stall", 32'(p1_stall_o), 32'd0);

    // Cold read miss on 0x40, clean refill: N+2 stall cycles
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("cold_stall_now", 32'(p1_stall_o), 32'd1);
    run_miss();
    check("cold_stall_len", n_stall, 32'd5);
    check("cold_no_wb", 32'(seen_wb), 32'd0);
    check("cold_rf_addr", rf_addr, 32'h0000_0040);
    check("cold_data", p1_data_o, 32'hA000_0040);

    // Read hit on word 1, same cycle
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    check("hit_stall", 32'(p1_stall_o), 32'd0);
    check("hit_data", p1_data_o, 32'hA000_0041);
    check("hit_no_mem", 32'(mem_enable_o), 32'd0);
    step();
    check("hit_no_mem_next", 32'(mem_enable_o), 32'd0);

    // Write hit, then dirty eviction by 0x440: 2N+3 stall cycles
    drive(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    check("whit_stall", 32'(p1_stall_o), 32'd0);
    step();
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("whit_readback", p1_data_o, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0000_0440, 32'h0);
    check("evict_stall_now", 32'(p1_stall_o), 32'd1);
    run_miss();
    check("evict_stall_len", n_stall, 32'd9);
    check("evict_wb_seen", 32'(seen_wb), 32'd1);
    check("evict_wb_first", 32'(wb_first), 32'd1);
    check("evict_wb_addr", wb_addr, 32'h0000_0040);
    check("evict_wb_word0", wb_line[31:0], 32'hDEAD_BEEF);
    check("evict_rf_addr", rf_addr, 32'h0000_0440);
    check("evict_data", p1_data_o, 32'hA000_0440);

    // Write miss on a clean line: refill 0x80, then the store lands
    drive(1'b0, 1'b1, 32'h0000_0088, 32'h1234_5678);
    check("wmiss_stall_now", 32'(p1_stall_o), 32'd1);
    run_miss();
    check("wmiss_stall_len", n_stall, 32'd5);
    check("wmiss_no_wb", 32'(seen_wb), 32'd0);
    check("wmiss_rf_addr", rf_addr, 32'h0000_0080);
    step();
    drive(1'b1, 1'b0, 32'h0000_0088, 32'h0);
    check("wmiss_read_stall", 32'(p1_stall_o), 32'd0);
    check("wmiss_read_data", p1_data_o, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h0000_008C, 32'h0);
    check("wmiss_other_word", p1_data_o, 32'hA000_0083);

    // Both controls high on a clean hit act as a store and set dirty
    drive(1'b1, 1'b1, 32'h0000_0444, 32'h55AA_55AA);
    check("both_stall", 32'(p1_stall_o), 32'd0);
    step();
    drive(1'b1, 1'b0, 32'h0000_0444, 32'h0);
    check("both_readback", p1_data_o, 32'h55AA_55AA);
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    run_miss();
    check("both_evict_len", n_stall, 32'd9);
    check("both_wb_addr", wb_addr, 32'h0000_0440);
    check("both_wb_word1", wb_line[63:32], 32'h55AA_55AA);
    check("both_rf_addr", rf_addr, 32'h0000_0040);
    check("both_refill_data", p1_data_o, 32'hA000_0041);
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("mem_roundtrip", p1_data_o, 32'hDEAD_BEEF);

    // Reset during REFILL, then a late ack
    drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    step();
    check("mid_rf_enable", 32'(mem_enable_o), 32'd1);
    check("mid_rf_write", 32'(mem_write_o), 32'd0);
    check("mid_rf_addr", mem_addr_o, 32'h0000_0100);
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", 32'(p1_stall_o), 32'd0);
    check("mid_rst_data", p1_data_o, 32'h0);
    check("mid_rst_enable", 32'(mem_enable_o), 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'h0);
    check("mid_rst_mdata", 32'(mem_data_o == '0), 32'd1);
    step();
    rst_i = 1'b1;
    force_ack = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("late_ack_stall", 32'(p1_stall_o), 32'd0);
    step();
    force_ack = 1'b0;
    #1;
    check("late_ack_enable", 32'(mem_enable_o), 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    check("post_rst_miss", 32'(p1_stall_o), 32'd1);
    run_miss();
    check("post_rst_len", n_stall, 32'd5);
    check("post_rst_no_wb", 32'(seen_wb), 32'd0);
    check("post_rst_data", p1_data_o, 32'hA000_0041);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("final_idle_data", p1_data_o, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
